// File: rtl/fsk_rx_framer.sv
// FSK receive framer: bit-timing recovery, sync-word hunt, length/payload capture onto a one-deep valid/ready output.
// Optional FSK_RX_CRC_EN adds a trailing CRC-8 (poly 0x07, init 0x00) check byte over the len and payload bytes.
module fsk_rx_framer #(
  parameter int          BIT_CLKS  = 1000,
  parameter logic [15:0] SYNC_WORD = 16'hD391,
  parameter int          MAX_LEN   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       demod_bit,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int            CW        = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] HALF_C    = CW'(BIT_CLKS / 2);
  localparam logic [CW-1:0] WRAP_C    = CW'(BIT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN_C = 8'(MAX_LEN);

`ifdef FSK_RX_CRC_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_HUNT = 3'd1, ST_LEN = 3'd2, ST_DATA = 3'd3, ST_CRC = 3'd4
  } state_t;

  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_HUNT = 3'd1, ST_LEN = 3'd2, ST_DATA = 3'd3
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [14:0]   hunt_q, hunt_d;
  logic [6:0]    sh_q, sh_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
`ifdef FSK_RX_CRC_EN
  logic [7:0]    crc_q, crc_d;
`endif

  logic        bit_s;
  logic        edge_s;
  logic        strobe_s;
  logic        mid_frame_s;
  logic [7:0]  byte_s;
  logic [15:0] hunt_s;

  assign bit_s       = sync_q[1];
  assign edge_s      = bit_s ^ prev_q;
  assign strobe_s    = (state_q != ST_IDLE) && (cnt_q == HALF_C);
  assign mid_frame_s = (state_q != ST_IDLE) && (state_q != ST_HUNT);
  assign byte_s      = {sh_q, bit_s};
  assign hunt_s      = {hunt_q, bit_s};

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sync_q    <= 2'b00;
      prev_q    <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      hunt_q    <= 15'd0;
      sh_q      <= 7'd0;
      bcnt_q    <= 3'd0;
      rem_q     <= 8'd0;
      m_data_q  <= 8'd0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FSK_RX_CRC_EN
      crc_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], demod_bit};
      prev_q    <= bit_s;
      cnt_q     <= cnt_d;
      hunt_q    <= hunt_d;
      sh_q      <= sh_d;
      bcnt_q    <= bcnt_d;
      rem_q     <= rem_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
`ifdef FSK_RX_CRC_EN
      crc_q     <= crc_d;
`endif
    end
  end

  // bit timing, framing FSM and output register next-state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hunt_d   = hunt_q;
    sh_d     = sh_q;
    bcnt_d   = bcnt_q;
    rem_d    = rem_q;
    m_data_d = m_data_q;
    m_last_d = m_last_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef FSK_RX_CRC_EN
    crc_d    = crc_q;
`endif
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    else                      m_valid_d = m_valid_q;

    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = {CW{1'b0}};
      hunt_d    = 15'd0;
      sh_d      = 7'd0;
      bcnt_d    = 3'd0;
      m_data_d  = 8'd0;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      err_d     = mid_frame_s;
    end else begin
      if (state_q == ST_IDLE)    cnt_d = {CW{1'b0}};
      else if (edge_s)           cnt_d = {CW{1'b0}};
      else if (cnt_q == WRAP_C)  cnt_d = {CW{1'b0}};
      else                       cnt_d = cnt_q + CW'(1);

      case (state_q)
        ST_IDLE: state_d = ST_HUNT;
        ST_HUNT: begin
          if (strobe_s) begin
            if (hunt_s == SYNC_WORD) begin
              state_d = ST_LEN;
              hunt_d  = 15'd0;
              sh_d    = 7'd0;
              bcnt_d  = 3'd0;
            end else begin
              hunt_d  = hunt_s[14:0];
            end
          end else begin
            hunt_d = hunt_q;
          end
        end
        ST_LEN: begin
          if (strobe_s) begin
            sh_d   = byte_s[6:0];
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              if ((byte_s == 8'd0) || (byte_s > MAX_LEN_C)) begin
                err_d   = 1'b1;
                state_d = ST_HUNT;
              end else begin
                rem_d   = byte_s;
                state_d = ST_DATA;
`ifdef FSK_RX_CRC_EN
                crc_d   = crc8_upd(8'd0, byte_s);
`endif
              end
            end else begin
              state_d = ST_LEN;
            end
          end else begin
            state_d = ST_LEN;
          end
        end
        ST_DATA: begin
          if (strobe_s) begin
            sh_d   = byte_s[6:0];
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              // a byte still held with no ready this cycle is an overrun; the held byte is kept
              if (m_valid_q && !m_ready) begin
                err_d   = 1'b1;
                state_d = ST_HUNT;
              end else begin
                m_data_d  = byte_s;
                m_valid_d = 1'b1;
                m_last_d  = (rem_q == 8'd1);
                rem_d     = rem_q - 8'd1;
`ifdef FSK_RX_CRC_EN
                crc_d     = crc8_upd(crc_q, byte_s);
                if (rem_q == 8'd1) state_d = ST_CRC;
                else               state_d = ST_DATA;
`else
                if (rem_q == 8'd1) begin
                  done_d  = 1'b1;
                  state_d = ST_HUNT;
                end else begin
                  state_d = ST_DATA;
                end
`endif
              end
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
`ifdef FSK_RX_CRC_EN
        ST_CRC: begin
          if (strobe_s) begin
            sh_d   = byte_s[6:0];
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              if (byte_s == crc_q) done_d = 1'b1;
              else                 err_d  = 1'b1;
              state_d = ST_HUNT;
            end else begin
              state_d = ST_CRC;
            end
          end else begin
            state_d = ST_CRC;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_HUNT);
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fsk_rx_framer.sv
// Self-checking bench for fsk_rx_framer: jittered FSK bit streams, randomized frames and ready, scoreboarded against a frame-level model.
module tb_fsk_rx_framer;

  localparam int          BC   = 20;
  localparam int          MAXL = 32;
  localparam logic [15:0] SW   = 16'hD391;

  logic       clk = 1'b0;
  logic       rst_n, enable, demod_bit, m_ready;
  logic [7:0] m_data;
  logic       m_valid, m_last, frame_done, frame_err, busy;

  fsk_rx_framer #(.BIT_CLKS(BC), .SYNC_WORD(SW), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .demod_bit(demod_bit),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit         bq[$];
  logic [7:0] pay[$];
  logic [8:0] obs[$];
  logic [8:0] exp_q[$];
  int         exp_done, exp_err;
  int         jit_prev = 0;
  bit         jit_en   = 1'b0;
  bit         rdy_mode = 1'b0;

  int done_cnt, err_cnt, valid_cyc, busy_cyc, stab_bad, both_bad;
  logic       hold_prev = 1'b0;
  logic [8:0] hold_val;

  // monitor: record transfers and pulses, watch held-data stability
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) obs.push_back({m_last, m_data});
      if (m_valid) valid_cyc++;
      if (busy) busy_cyc++;
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
      if (frame_done && frame_err) both_bad++;
      if (hold_prev && m_valid && ({m_last, m_data} !== hold_val)) stab_bad++;
      hold_prev = m_valid && !m_ready;
      hold_val  = {m_last, m_data};
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    obs.delete();
    done_cnt = 0; err_cnt = 0; valid_cyc = 0; busy_cyc = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bq.push_back(b[i]);
  endtask

  task automatic push16(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) bq.push_back(w[i]);
  endtask

  // edges land at nominal bit boundaries +/-2 clocks (10% of a bit), non-cumulative
  task automatic send_bits(input int n);
    int cnt;
    int nxt;
    int dur;
    cnt = 0;
    while (cnt < n && bq.size() > 0) begin
      demod_bit = bq.pop_front();
      nxt = jit_en ? (int'($urandom_range(0, 4)) - 2) : 0;
      dur = BC + nxt - jit_prev;
      jit_prev = nxt;
      repeat (dur) @(posedge clk);
      #1;
      cnt++;
    end
  endtask

`ifdef FSK_RX_CRC_EN
  // CRC as remainder of (len, payload) * x^8 modulo x^8+x^2+x+1
  function automatic logic [7:0] crc_ref(input logic [7:0] len);
    logic [7:0] m[$];
    logic [8:0] r;
    m = pay;
    m.push_front(len);
    r = 9'd0;
    for (int j = 0; j < m.size(); j++)
      for (int i = 7; i >= 0; i--) begin
        r = {r[7:0], m[j][i]};
        if (r[8]) r = r ^ 9'h107;
      end
    for (int i = 0; i < 8; i++) begin
      r = {r[7:0], 1'b0};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction
`endif

  task automatic push_frame(input logic [7:0] len, input bit flip);
    bit ok;
    ok = (len != 8'd0) && (len <= 8'(MAXL));
    push_byte(8'hAA);
    push16(SW);
    push_byte(len);
    if (ok) begin
      foreach (pay[i]) push_byte(pay[i]);
`ifdef FSK_RX_CRC_EN
      push_byte(crc_ref(len) ^ {7'd0, flip});
`endif
    end
    push_byte(8'hAA);
  endtask

  // frame-level model of what the receiver should deliver
  task automatic make_exp(input logic [7:0] len, input bit flip);
    bit ok;
    ok = (len != 8'd0) && (len <= 8'(MAXL));
    exp_q.delete();
    if (ok) for (int i = 0; i < int'(len); i++) exp_q.push_back({(i == int'(len) - 1), pay[i]});
    exp_done = ok ? 1 : 0;
`ifdef FSK_RX_CRC_EN
    if (flip) exp_done = 0;
`endif
    exp_err = 1 - exp_done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; demod_bit = 1'b0; m_ready = 1'b1;
    #23;
    total++;
    if ({m_data, m_valid, m_last, frame_done, frame_err, busy} !== 13'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {m_data, m_valid, m_last, frame_done, frame_err, busy});
    end
    @(posedge clk); #1;
    rst_n = 1'b1; enable = 1'b1;
    step(3);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL hunt_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    clear_mon();
    pay.delete(); pay.push_back(8'hA5); pay.push_back(8'h3C);
    push_frame(8'd2, 1'b0);
    send_bits(100000);
    total++;
    if (obs.size() !== 2) begin bad++; $display("FAIL basic_count got=%0d exp=2", obs.size()); end
    total++;
    if (obs[0] !== 9'h0A5) begin bad++; $display("FAIL basic_byte0 got=%h exp=0a5", obs[0]); end
    total++;
    if (obs[1] !== 9'h13C) begin bad++; $display("FAIL basic_byte1 got=%h exp=13c", obs[1]); end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
    total++;
    if (err_cnt !== 0) begin bad++; $display("FAIL basic_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_len_err();
    logic [7:0] lens [2];
    lens[0] = 8'h00; lens[1] = 8'h21;
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      pay.delete();
      push_frame(lens[k], 1'b0);
      send_bits(100000);
      total++;
      if ({err_cnt, done_cnt, valid_cyc} !== {32'd1, 32'd0, 32'd0}) begin
        bad++; $display("FAIL len_err_%0d got err=%0d done=%0d valid=%0d exp 1/0/0", k, err_cnt, done_cnt, valid_cyc);
      end
    end
    clear_mon();
    pay.delete(); pay.push_back(8'($urandom));
    push_frame(8'd1, 1'b0);
    make_exp(8'd1, 1'b0);
    send_bits(100000);
    total++;
    if (obs.size() !== 1 || obs[0] !== exp_q[0]) begin
      bad++; $display("FAIL len_err_recover got n=%0d %h exp %h", obs.size(), obs[0], exp_q[0]);
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL len_err_recover_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_overrun();
    m_ready = 1'b0;
    clear_mon();
    pay.delete(); pay.push_back(8'hA5); pay.push_back(8'h3C); pay.push_back(8'h5A);
    push_frame(8'd3, 1'b0);
    send_bits(100000);
    total++;
    if ({err_cnt, done_cnt} !== {32'd1, 32'd0}) begin
      bad++; $display("FAIL overrun_pulses got err=%0d done=%0d exp 1/0", err_cnt, done_cnt);
    end
    total++;
    if ({m_valid, m_last, m_data} !== 10'h2A5) begin
      bad++; $display("FAIL overrun_hold got=%h exp=2a5", {m_valid, m_last, m_data});
    end
    m_ready = 1'b1;
    step(1);
    total++;
    if (obs.size() !== 1 || obs[0] !== 9'h0A5) begin
      bad++; $display("FAIL overrun_accept got n=%0d %h exp 0a5", obs.size(), obs[0]);
    end
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL overrun_drop got=%b exp=0", m_valid); end
  endtask

  task automatic test_jitter();
    logic [7:0] len;
    jit_en = 1'b1;
    clear_mon();
    push_byte(8'hAA);
    bq.push_back(1'b1);
    push16(16'hD390);
    push_byte(8'hAA); push_byte(8'hAA);
    send_bits(100000);
    total++;
    if ({busy_cyc, err_cnt, valid_cyc} !== 96'd0) begin
      bad++; $display("FAIL false_sync got busy=%0d err=%0d valid=%0d exp 0", busy_cyc, err_cnt, valid_cyc);
    end
    clear_mon();
    len = 8'($urandom_range(1, 4));
    pay.delete();
    for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom));
    push_frame(len, 1'b0);
    make_exp(len, 1'b0);
    send_bits(100000);
    jit_en = 1'b0;
    total++;
    if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL jitter_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL jitter_byte%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
    end
    total++;
    if (done_cnt !== exp_done) begin bad++; $display("FAIL jitter_done got=%0d exp=%0d", done_cnt, exp_done); end
  endtask

  task automatic test_random();
    logic [7:0] len;
    bit flip;
    rdy_mode = 1'b1;
    for (int f = 0; f < 6; f++) begin
      len  = (f == 0) ? 8'(MAXL) : 8'($urandom_range(1, 8));
      flip = 1'b0;
`ifdef FSK_RX_CRC_EN
      flip = ($urandom_range(0, 1) == 1);
`endif
      pay.delete();
      for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom));
      clear_mon();
      push_frame(len, flip);
      make_exp(len, flip);
      send_bits(100000);
      total++;
      if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", f, obs.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        total++;
        if (obs[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", f, i, obs[i], exp_q[i]); end
      end
      total++;
      if ({done_cnt, err_cnt} !== {exp_done, exp_err}) begin
        bad++; $display("FAIL rand%0d_status got done=%0d err=%0d exp %0d/%0d", f, done_cnt, err_cnt, exp_done, exp_err);
      end
    end
    rdy_mode = 1'b0;
    step(1);
    m_ready = 1'b1;
  endtask

  task automatic test_enable_drop();
    clear_mon();
    pay.delete(); pay.push_back(8'hA5); pay.push_back(8'h3C); pay.push_back(8'h5A);
    push_frame(8'd3, 1'b0);
    send_bits(44);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL endrop_busy_before got=%b exp=1", busy); end
    enable = 1'b0;
    step(1);
    total++;
    if ({frame_err, m_valid, busy} !== 3'b100) begin
      bad++; $display("FAIL endrop_outputs got=%b exp=100", {frame_err, m_valid, busy});
    end
    step(1);
    total++;
    if ({frame_err, err_cnt, done_cnt} !== {1'b0, 32'd1, 32'd0}) begin
      bad++; $display("FAIL endrop_pulse got err=%b cnt=%0d done=%0d exp 0/1/0", frame_err, err_cnt, done_cnt);
    end
    total++;
    if (obs.size() !== 1 || obs[0] !== 9'h0A5) begin
      bad++; $display("FAIL endrop_first_byte got n=%0d %h exp 0a5", obs.size(), obs[0]);
    end
    bq.delete();
    enable = 1'b1;
    step(2);
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    clear_mon();
    pay.delete(); pay.push_back(8'hA5); pay.push_back(8'h3C); pay.push_back(8'h5A);
    push_frame(8'd3, 1'b0);
    send_bits(44);
    total++;
    if ({m_valid, m_data, busy} !== 10'h34B) begin
      bad++; $display("FAIL rstmid_before got=%h exp=34b", {m_valid, m_data, busy});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({m_data, m_valid, m_last, frame_done, frame_err, busy} !== 13'd0) begin
      bad++; $display("FAIL rstmid_outputs got=%h exp=0", {m_data, m_valid, m_last, frame_done, frame_err, busy});
    end
    step(2);
    rst_n = 1'b1;
    m_ready = 1'b1;
    bq.delete();
    step(3);
  endtask

`ifdef FSK_RX_CRC_EN
  task automatic test_crc();
    logic [7:0] crcs [2];
    crcs[0] = 8'h15; crcs[1] = 8'h14;
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      push_byte(8'hAA); push16(SW); push_byte(8'h01); push_byte(8'h00); push_byte(crcs[k]); push_byte(8'hAA);
      send_bits(100000);
      total++;
      if (obs.size() !== 1 || obs[0] !== 9'h100) begin
        bad++; $display("FAIL crc%0d_byte got n=%0d %h exp 100", k, obs.size(), obs[0]);
      end
      total++;
      if ({done_cnt, err_cnt} !== ((k == 0) ? {32'd1, 32'd0} : {32'd0, 32'd1})) begin
        bad++; $display("FAIL crc%0d_status got done=%0d err=%0d", k, done_cnt, err_cnt);
      end
    end
  endtask
`endif

  task automatic test_global();
    total++;
    if (both_bad !== 0) begin bad++; $display("FAIL done_err_overlap got=%0d exp=0", both_bad); end
    total++;
    if (stab_bad !== 0) begin bad++; $display("FAIL held_stability got=%0d exp=0", stab_bad); end
  endtask

  initial begin
    stab_bad = 0; both_bad = 0;
    clear_mon();
    test_reset();
    test_basic();
    test_len_err();
    test_overrun();
    test_jitter();
    test_random();
    test_enable_drop();
    test_reset_mid();
`ifdef FSK_RX_CRC_EN
    test_crc();
`endif
    test_global();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsk_rx_framer.md
# fsk_rx_framer

Receive-side frame controller placed directly after the FSK demodulator. It recovers bit timing from the demodulated bit stream and hunts for a 16-bit sync word. It then collects a length byte and the payload bytes, and presents each byte on a single-entry valid/ready output. It also sequences frame status (done/error) for the downstream packet logic.

## Interface
- BIT_CLKS, 1000: clock cycles per FSK bit; must be ≥ 4 and even.
- SYNC_WORD, 16'hD391: sync pattern, transmitted MSB first.
- MAX_LEN, 32: largest legal payload length in bytes (1..255).

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  framer run enable; low forces IDLE
- demod_bit  in  1  demodulated bit stream (asynchronous to bit timing)
- m_data  out  8  payload byte
- m_valid  out  1  m_data valid; held until m_ready
- m_ready  in  1  downstream accepts byte
- m_last  out  1  qualifies m_data as final payload byte
- frame_done  out  1  one-cycle pulse: frame completed without error
- frame_err  out  1  one-cycle pulse: frame aborted or failed
- busy  out  1  high in any state other than IDLE/HUNT

## Operation
- Input: demod_bit passes through a 2-flop synchronizer before any other use.
- Bit timing:
  - Bit-phase counter runs 0..BIT_CLKS-1 and wraps.
  - Any transition of the synchronized bit resets the counter to 0.
  - Sample strobe fires when counter == BIT_CLKS/2.
- All bits are shifted MSB first.
- IDLE: entered while enable=0. Counter, shift registers and output register are cleared. Moves to HUNT on the first cycle enable=1.
- HUNT: each strobe shifts a 16-bit register. On a match with SYNC_WORD, move to LEN and clear the bit count.
- LEN: collect 8 bits into len.
  - len==0 or len>MAX_LEN: pulse frame_err, return to HUNT.
  - Otherwise go to DATA with a remaining-byte counter set to len.
- DATA: every 8 strobes completes a byte.
  - Output register empty (m_valid=0): load m_data, set m_valid, set m_last if remaining==1, decrement remaining.
  - Output register full (m_valid=1 and m_ready=0 in that cycle): overrun. Pulse frame_err, keep the held byte, return to HUNT.
  - Output register full, m_ready=1 in the same cycle: counts as empty; the new byte loads.
  - After the final byte loads, terminate: pulse frame_done and go to HUNT (CRC disabled).
- Handshake: a transfer occurs when m_valid && m_ready. m_valid drops the next cycle unless a new byte loads that same cycle. m_data and m_last are stable while m_valid=1 && !m_ready.
- enable falling mid-frame (LEN/DATA/CRC): pulse frame_err, clear m_valid, enter IDLE next cycle.
- frame_done and frame_err never assert in the same cycle.

## Timing
- Reset values: m_data=0, m_valid=0, m_last=0, frame_done=0, frame_err=0, busy=0. State = IDLE.
- Reset is asynchronous and may assert mid-frame; all state is cleared immediately.
- Latency: m_valid rises 1 clk after the strobe sampling a byte's 8th bit.
- frame_done/frame_err rise 1 clk after the terminating strobe (or after enable drops).
- Synchronizer delay: 2 clk from demod_bit to bit-phase reset.

## Configuration
- FSK_RX_CRC_EN defined:
  - A CRC state follows the final payload byte.
  - CRC-8 is polynomial 0x07, init 0x00, computed MSB first over the len byte and all payload bytes.
  - The CRC byte is received but not output.
  - Match: pulse frame_done. Mismatch: pulse frame_err.
  - Both then return to HUNT.
- FSK_RX_CRC_EN undefined: no CRC state or CRC logic. The frame terminates after the final payload byte, as described in Operation.

## Test plan
- Reset, enable=1, send sync 0xD391, len 0x02, bytes 0xA5 0x3C, m_ready=1: two transfers 0xA5 (m_last=0) then 0x3C (m_last=1); one frame_done pulse.
- Send sync then len 0x00, and separately len 0x21 (MAX_LEN=32): frame_err pulse each time, no m_valid, back to HUNT; the next valid frame is received.
- len 0x03, hold m_ready=0 throughout: first byte held stable; frame_err on completion of the second byte; m_data stays 0xA5 until accepted.
- Bit stream with ±10% bit-period jitter on transitions, 1 bit preceding a false sync (0xD390): no lock on the false pattern; the true frame decodes correctly.
- Drop enable during the second payload byte: frame_err pulse, m_valid=0, busy=0 within 1 clk. Assert rst_n=0 mid-byte: all outputs 0 immediately.
- FSK_RX_CRC_EN: len 0x01, payload 0x00, CRC 0x15 gives frame_done. The same frame with CRC 0x14 gives frame_err; byte 0x00 is still output with m_last=1.
